text_renderer: RTL and testbench
================================

TEXT_RENDERER -- requirements
Module: text_renderer

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns per line.
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows per screen.
REQ-003 SHALL have parameter BLINK_BIT, default 4, meaning the frame-counter bit that sets cursor blink phase.
REQ-004 iClk  input  1  sole clock; all state rising-edge.
REQ-005 iRst_n  input  1  reset, asynchronous, active-low.
REQ-006 iX  input  10  current pixel column from timing generator.
REQ-007 iY  input  10  current pixel line from timing generator.
REQ-008 iActive  input  1  visible-area flag for iX/iY.
REQ-009 iHsync, iVsync  input  1 each  sync pulses, active-high.
REQ-010 oTextAddr  output  12  text buffer address (row*COLS + col).
REQ-011 iTextData  input  16  text buffer word, returned 1 clock after oTextAddr: [7:0] char code, [11:8] fg index, [15:12] bg index.
REQ-012 oChar  output  8  character code to font ROM.
REQ-013 oRow  output  4  glyph row to font ROM.
REQ-014 iLine  input  8  glyph bitmap from font ROM, combinational from oChar/oRow; bit 7 = leftmost pixel.
REQ-015 iCurX  input  7  cursor column.
REQ-016 iCurY  input  5  cursor row.
REQ-017 iCurEn  input  1  cursor enable.
REQ-018 oRGB  output  12  pixel colour, 4 bits each R,G,B.
REQ-019 oHsync, oVsync, oActive  output  1 each  syncs/active aligned with oRGB.

Function
REQ-020 Stage 1 SHALL register oTextAddr = iY[9:4]*COLS + iX[9:3], plus iX[2:0], iY[3:0], iActive, syncs and cell coordinates.
REQ-021 Stage 2 SHALL drive oChar = iTextData[7:0] and oRow = stage-1 iY[3:0] combinationally, and SHALL register the selected pixel bit iLine[7 - x[2:0]] together with the fg/bg indices.
REQ-022 Stage 3 SHALL register oRGB = palette(fg) for a set bit and palette(bg) for a clear bit.
REQ-023 Total latency from iX/iY/iActive/iHsync/iVsync to oRGB/oActive/oHsync/oVsync SHALL be exactly 3 clocks, with one result per clock and no stalls.
REQ-024 oRGB SHALL be 12'h000 when the delayed active flag is 0.
REQ-025 oRGB SHALL be 12'h000 when the cell lies outside the grid (col >= COLS or row >= ROWS).
REQ-026 For out-of-grid cells, oTextAddr SHALL be 0 and never exceed COLS*ROWS-1.
REQ-027 Palette SHALL be the fixed 16-entry CGA-style table (0 = 000, 7 = AAA, 15 = FFF).
REQ-028 A 6-bit frame counter SHALL increment on each iVsync rising edge (registered edge detect) and wrap 63 -> 0.
REQ-029 Cursor SHALL be shown when all hold: iCurEn=1, counter[BLINK_BIT]=0, the cell equals (iCurX, iCurY), and glyph row is 14 or 15.
REQ-030 While the cursor is shown, the pixel SHALL be forced to fg colour regardless of iLine.
REQ-031 iCurX/iCurY/iCurEn SHALL be sampled in stage 1 with the pixel, so mid-frame changes take effect on the next pixel.
REQ-032 Cursor coordinates outside the grid SHALL never display.

Reset
REQ-033 While iRst_n=0, all pipeline registers, the frame counter, the vsync edge register, oTextAddr, oRGB, oHsync, oVsync and oActive SHALL be 0.
REQ-034 Reset assertion mid-line SHALL clear outputs immediately (asynchronous).
REQ-035 After deassertion, the first valid oRGB SHALL appear 3 clocks after the first sampled input, with no garbage output before it (flags stay 0).

Structure
REQ-036 COLS/ROWS defaults, attribute field positions, and the 16-entry palette table SHALL live in the shared display package.
REQ-037 Palette lookup SHALL be one combinational sub-module, text_palette (4-bit index -> 12-bit RGB), instantiated twice or muxed once.
REQ-038 The font ROM and text buffer SHALL be external; this block only drives their addresses.

Verification
REQ-039 Bench: iX=17, iY=35, iActive=1 -> oTextAddr=162 one clock later; oRow=3 and oChar=iTextData[7:0] the following clock.
REQ-040 Bench: char 0x41 with fg=15, bg=1, glyph row 0x18, x[2:0]=3 -> oRGB=12'hFFF 3 clocks after input; x[2:0]=0 -> 12'h00A.
REQ-041 Bench: iActive=0, or iX=640 with COLS=80 -> oRGB=12'h000 and oTextAddr within 0..2399.
REQ-042 Bench: iCurEn=1, cursor at (5,2), iY=46 (row 14), blank glyph, counter=0 -> fg colour at x 40..47; after 16 vsync rising edges -> bg colour.
REQ-043 Bench: 64 vsync pulses -> counter wraps to 0 and blink phase repeats.
REQ-044 Bench: iRst_n low mid-stream -> all outputs 0 within the same cycle; after release, oActive rises exactly 3 clocks after the first iActive=1.

Source files
------------

// File: rtl/text_renderer_pkg.sv
// Shared display definitions: grid defaults, text-word layout and the 16-colour palette.
package text_renderer_pkg;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 30;

    // Text buffer word layout, MSB first: [15:12] bg, [11:8] fg, [7:0] char code.
    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
        logic [7:0] code;
    } text_word_t;

    // CGA-style palette; entry 0 is the rightmost element.
    localparam logic [15:0][11:0] PALETTE = {
        12'hFFF, 12'hFF5, 12'hF5F, 12'hF55,
        12'h5FF, 12'h5F5, 12'h55F, 12'h555,
        12'hAAA, 12'hA50, 12'hA0A, 12'hA00,
        12'h0AA, 12'h0A0, 12'h00A, 12'h000
    };

endpackage

// File: rtl/text_palette.sv
// Combinational 4-bit colour index to 12-bit RGB lookup.
module text_palette
    import text_renderer_pkg::*;
(
    input  logic [3:0]  idx,
    output logic [11:0] rgb
);

    assign rgb = PALETTE[idx];

endmodule

// File: rtl/text_renderer.sv
// Three-stage text-mode pixel pipeline: address -> glyph bit -> palette colour.
module text_renderer
    import text_renderer_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int BLINK_BIT = 4
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic [9:0]  iX,
    input  logic [9:0]  iY,
    input  logic        iActive,
    input  logic        iHsync,
    input  logic        iVsync,
    output logic [11:0] oTextAddr,
    input  logic [15:0] iTextData,
    output logic [7:0]  oChar,
    output logic [3:0]  oRow,
    input  logic [7:0]  iLine,
    input  logic [6:0]  iCurX,
    input  logic [4:0]  iCurY,
    input  logic        iCurEn,
    output logic [11:0] oRGB,
    output logic        oHsync,
    output logic        oVsync,
    output logic        oActive
);

    localparam logic [7:0] COLS_L = 8'(COLS);
    localparam logic [7:0] ROWS_L = 8'(ROWS);

    // Stage-1 cell decode
    logic [6:0]  col;
    logic [5:0]  row;
    logic        in_grid;
    logic        cur_hit;
    logic [11:0] addr_nxt;

    assign col     = iX[9:3];
    assign row     = iY[9:4];
    assign in_grid = ({1'b0, col} < COLS_L) && ({2'b00, row} < ROWS_L);

    // Out-of-grid cells park the address at 0 so the buffer is never overrun.
    assign addr_nxt = in_grid ? 12'(int'(row) * COLS + int'(col)) : 12'd0;

    logic [5:0] frame_cnt;
    logic       vs_q;

    assign cur_hit = iCurEn && !frame_cnt[BLINK_BIT]
                  && ({1'b0, iCurX} < COLS_L) && ({3'b000, iCurY} < ROWS_L)
                  && (col == iCurX) && (row == {1'b0, iCurY})
                  && (iY[3:1] == 3'b111);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            vs_q      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vs_q <= iVsync;
            if (iVsync && !vs_q)
                frame_cnt <= frame_cnt + 6'd1;
        end
    end

    logic [2:0] vld_pipe;
    logic [2:0] hs_pipe;
    logic [2:0] vs_pipe;
    logic [2:0] s1_xsub;
    logic [3:0] s1_yrow;
    logic       s1_in_grid;
    logic       s1_cur;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            vld_pipe   <= '0;
            hs_pipe    <= '0;
            vs_pipe    <= '0;
            oTextAddr  <= '0;
            s1_xsub    <= '0;
            s1_yrow    <= '0;
            s1_in_grid <= 1'b0;
            s1_cur     <= 1'b0;
        end else begin
            vld_pipe   <= {vld_pipe[1:0], iActive};
            hs_pipe    <= {hs_pipe[1:0], iHsync};
            vs_pipe    <= {vs_pipe[1:0], iVsync};
            oTextAddr  <= addr_nxt;
            s1_xsub    <= iX[2:0];
            s1_yrow    <= iY[3:0];
            s1_in_grid <= in_grid;
            s1_cur     <= cur_hit;
        end
    end

    // Stage 2: text word and glyph line arrive combinationally this cycle.
    text_word_t tw;
    assign tw    = text_word_t'(iTextData);
    assign oChar = tw.code;
    assign oRow  = s1_yrow;

    logic       s2_pix;
    logic       s2_show;
    logic [3:0] s2_fg;
    logic [3:0] s2_bg;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s2_pix  <= 1'b0;
            s2_show <= 1'b0;
            s2_fg   <= '0;
            s2_bg   <= '0;
        end else begin
            s2_pix  <= s1_cur | iLine[3'd7 - s1_xsub];
            s2_show <= vld_pipe[0] & s1_in_grid;
            s2_fg   <= tw.fg;
            s2_bg   <= tw.bg;
        end
    end

    // Stage 3: one palette instance fed by the fg/bg mux.
    logic [11:0] pal_rgb;

    text_palette u_palette (
        .idx (s2_pix ? s2_fg : s2_bg),
        .rgb (pal_rgb)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)
            oRGB <= '0;
        else
            oRGB <= s2_show ? pal_rgb : 12'h000;
    end

    assign oActive = vld_pipe[2];
    assign oHsync  = hs_pipe[2];
    assign oVsync  = vs_pipe[2];

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer with small text-buffer and font-ROM models.
module tb_text_renderer;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic [9:0]  iX, iY;
    logic        iActive, iHsync, iVsync;
    logic [11:0] oTextAddr;
    logic [15:0] iTextData;
    logic [7:0]  oChar;
    logic [3:0]  oRow;
    logic [7:0]  iLine;
    logic [6:0]  iCurX;
    logic [4:0]  iCurY;
    logic        iCurEn;
    logic [11:0] oRGB;
    logic        oHsync, oVsync, oActive;

    int checks = 0;
    int fails  = 0;

    text_renderer dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iX        (iX),
        .iY        (iY),
        .iActive   (iActive),
        .iHsync    (iHsync),
        .iVsync    (iVsync),
        .oTextAddr (oTextAddr),
        .iTextData (iTextData),
        .oChar     (oChar),
        .oRow      (oRow),
        .iLine     (iLine),
        .iCurX     (iCurX),
        .iCurY     (iCurY),
        .iCurEn    (iCurEn),
        .oRGB      (oRGB),
        .oHsync    (oHsync),
        .oVsync    (oVsync),
        .oActive   (oActive)
    );

    always #5 iClk = ~iClk;

    // Text buffer: cell (2,2) = 'A' fg15/bg1, cell (5,2) = blank fg14/bg1, rest blank fg7/bg2.
    always_comb begin
        case (oTextAddr)
            12'd162: iTextData = 16'h1F41;
            12'd165: iTextData = 16'h1E20;
            default: iTextData = 16'h2720;
        endcase
    end

    assign iLine = (oChar == 8'h41) ? 8'h18 : 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic act);
        iX = x; iY = y; iActive = act;
    endtask

    task automatic hold3();
        tick(); tick(); tick();
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            iVsync = 1'b1; tick();
            iVsync = 1'b0; tick();
        end
    endtask

    initial begin
        iRst_n = 1'b0; iHsync = 1'b0; iVsync = 1'b0;
        iCurEn = 1'b0; iCurX = 7'd0; iCurY = 5'd0;
        pix(10'd17, 10'd35, 1'b1);
        tick(); tick();
        chk("rst_rgb",    32'(oRGB), 32'h000);
        chk("rst_active", 32'(oActive), 32'd0);
        chk("rst_addr",   32'(oTextAddr), 32'd0);
        chk("rst_hsync",  32'(oHsync), 32'd0);

        iRst_n = 1'b1;
        pix(10'd17, 10'd35, 1'b1);
        tick();
        chk("addr_162", 32'(oTextAddr), 32'd162);
        chk("row_3",    32'(oRow), 32'd3);
        chk("char_41",  32'(oChar), 32'h41);
        chk("act_lat1", 32'(oActive), 32'd0);
        pix(10'd19, 10'd35, 1'b1);
        tick();
        chk("act_lat2", 32'(oActive), 32'd0);
        pix(10'd16, 10'd35, 1'b1);
        tick();
        chk("rgb_x1_bg",  32'(oRGB), 32'h00A);
        chk("act_lat3",   32'(oActive), 32'd1);
        pix(10'd20, 10'd35, 1'b1);
        tick();
        chk("rgb_x3_fg",  32'(oRGB), 32'hFFF);
        pix(10'd21, 10'd35, 1'b1);
        tick();
        chk("rgb_x0_bg",  32'(oRGB), 32'h00A);
        tick();
        chk("rgb_x4_fg",  32'(oRGB), 32'hFFF);
        tick();
        chk("rgb_x5_bg",  32'(oRGB), 32'h00A);

        pix(10'd19, 10'd35, 1'b0);
        hold3();
        chk("inactive_rgb", 32'(oRGB), 32'h000);
        chk("inactive_flg", 32'(oActive), 32'd0);

        pix(10'd640, 10'd35, 1'b1);
        tick();
        chk("col80_addr", 32'(oTextAddr), 32'd0);
        tick(); tick();
        chk("col80_rgb",  32'(oRGB), 32'h000);
        chk("col80_act",  32'(oActive), 32'd1);
        pix(10'd639, 10'd479, 1'b1);
        tick();
        chk("last_addr", 32'(oTextAddr), 32'd2399);
        tick(); tick();
        chk("last_rgb",  32'(oRGB), 32'h0A0);
        pix(10'd0, 10'd480, 1'b1);
        tick();
        chk("row30_addr", 32'(oTextAddr), 32'd0);
        tick(); tick();
        chk("row30_rgb",  32'(oRGB), 32'h000);

        iHsync = 1'b1; tick();
        iHsync = 1'b0; tick(); tick();
        chk("hsync_on",  32'(oHsync), 32'd1);
        tick();
        chk("hsync_off", 32'(oHsync), 32'd0);

        iCurEn = 1'b1; iCurX = 7'd5; iCurY = 5'd2;
        pix(10'd40, 10'd46, 1'b1); hold3();
        chk("cur_x40",   32'(oRGB), 32'hFF5);
        pix(10'd47, 10'd46, 1'b1); hold3();
        chk("cur_x47",   32'(oRGB), 32'hFF5);
        pix(10'd48, 10'd46, 1'b1); hold3();
        chk("cur_x48",   32'(oRGB), 32'h0A0);
        pix(10'd40, 10'd45, 1'b1); hold3();
        chk("cur_row13", 32'(oRGB), 32'h00A);
        iCurEn = 1'b0;
        pix(10'd40, 10'd46, 1'b1); hold3();
        chk("cur_off",   32'(oRGB), 32'h00A);
        iCurEn = 1'b1; iCurX = 7'd100;
        pix(10'd800, 10'd46, 1'b1); hold3();
        chk("cur_oog",   32'(oRGB), 32'h000);
        iCurX = 7'd5;

        pix(10'd40, 10'd46, 1'b1);
        vs_pulses(15); hold3();
        chk("blink_15", 32'(oRGB), 32'hFF5);
        vs_pulses(1); hold3();
        chk("blink_16", 32'(oRGB), 32'h00A);
        vs_pulses(48); hold3();
        chk("blink_64", 32'(oRGB), 32'hFF5);
        vs_pulses(16); hold3();
        chk("blink_80", 32'(oRGB), 32'h00A);

        iCurEn = 1'b0;
        pix(10'd20, 10'd35, 1'b1); hold3();
        chk("pre_rst_rgb", 32'(oRGB), 32'hFFF);
        iRst_n = 1'b0;
        #1;
        chk("mid_rst_rgb",  32'(oRGB), 32'h000);
        chk("mid_rst_act",  32'(oActive), 32'd0);
        chk("mid_rst_addr", 32'(oTextAddr), 32'd0);
        tick();
        iRst_n = 1'b1;
        pix(10'd20, 10'd35, 1'b0);
        tick(); tick();
        chk("post_rst_idle", 32'(oActive), 32'd0);
        pix(10'd20, 10'd35, 1'b1);
        tick();
        chk("post_rst_l1", 32'(oActive), 32'd0);
        tick();
        chk("post_rst_l2", 32'(oActive), 32'd0);
        tick();
        chk("post_rst_l3", 32'(oActive), 32'd1);
        chk("post_rst_rgb", 32'(oRGB), 32'hFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
